// File: rtl/parking_input_frontend.sv
// Input conditioning for the parking controller: synchronised, debounced gate
// sensors with arbitrated one-cycle event pulses, plus a serial 4-bit keypad assembler.
module parking_input_frontend #(
    parameter int unsigned DEBOUNCE_CYCLES    = 4,
    parameter int unsigned PWD_HOLD_CYCLES    = 2,
    parameter int unsigned KEY_TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_raw,
    input  logic       exit_raw,
    input  logic       key_strobe,
    input  logic       key_bit,
    input  logic       key_clear,
    output logic       sensor_entry,
    output logic       sensor_exit,
    output logic [3:0] password,
    output logic       pwd_valid,
    output logic       key_busy,
    output logic       event_dropped
);

    localparam logic [7:0]  DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  HOLD_LAST = 8'(PWD_HOLD_CYCLES - 1);
    localparam logic [15:0] TO_LAST   = 16'(KEY_TIMEOUT_CYCLES - 1);

    // Index 0 is the entry sensor, index 1 the exit sensor.
    logic [1:0]      w_raw;
    logic [1:0]      r_sync1;
    logic [1:0]      r_sync2;
    logic [1:0]      r_deb;
    logic [1:0]      r_pend;
    logic [1:0][7:0] r_dcnt;
    logic [1:0]      w_rise;
    logic [1:0]      w_issue;
    logic            w_drop;
    logic            r_entry;
    logic            r_exit;
    logic            r_dropped;

    assign w_raw = {exit_raw, entry_raw};

    always_comb begin
        w_rise = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            w_rise[i] = (r_sync2[i] != r_deb[i]) && (r_dcnt[i] == DEB_LAST) && !r_deb[i];
        end
        // Entry wins; a pending exit waits one cycle behind a pending entry.
        w_issue[0] = r_pend[0];
        w_issue[1] = r_pend[1] & ~r_pend[0];
        w_drop     = |(w_rise & r_pend & ~w_issue);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_deb     <= '0;
            r_pend    <= '0;
            r_dcnt    <= '0;
            r_entry   <= 1'b0;
            r_exit    <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int unsigned i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_dcnt[i] <= '0;
                end else if (r_dcnt[i] == DEB_LAST) begin
                    r_deb[i]  <= ~r_deb[i];
                    r_dcnt[i] <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + 8'd1;
                end
            end
            r_pend  <= w_rise | (r_pend & ~w_issue);
            r_entry <= w_issue[0];
            r_exit  <= w_issue[1];
            if (w_drop) begin
                r_dropped <= 1'b1;
            end
        end
    end

    typedef enum logic [1:0] {P_IDLE, P_COLLECT, P_HOLD} pstate_t;

    pstate_t     r_state, w_state_nxt;
    logic [3:0]  r_shift, w_shift_nxt;
    logic [1:0]  r_bitcnt, w_bitcnt_nxt;
    logic [15:0] r_idle, w_idle_nxt;
    logic [7:0]  r_hold, w_hold_nxt;
    logic [3:0]  r_pwd, w_pwd_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= P_IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_idle   <= '0;
            r_hold   <= '0;
            r_pwd    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_idle   <= w_idle_nxt;
            r_hold   <= w_hold_nxt;
            r_pwd    <= w_pwd_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_idle_nxt   = r_idle;
        w_hold_nxt   = r_hold;
        w_pwd_nxt    = r_pwd;
        case (r_state)
            P_IDLE: begin
                if (key_strobe && !key_clear) begin
                    w_shift_nxt  = {3'b000, key_bit};
                    w_bitcnt_nxt = 2'd1;
                    w_idle_nxt   = '0;
                    w_state_nxt  = P_COLLECT;
                end
            end
            P_COLLECT: begin
                if (key_clear) begin
                    w_shift_nxt  = '0;
                    w_bitcnt_nxt = '0;
                    w_idle_nxt   = '0;
                    w_state_nxt  = P_IDLE;
                end else if (key_strobe) begin
                    w_idle_nxt = '0;
                    if (r_bitcnt == 2'd3) begin
                        w_pwd_nxt    = {r_shift[2:0], key_bit};
                        w_shift_nxt  = '0;
                        w_bitcnt_nxt = '0;
                        w_hold_nxt   = '0;
                        w_state_nxt  = P_HOLD;
                    end else begin
                        w_shift_nxt  = {r_shift[2:0], key_bit};
                        w_bitcnt_nxt = r_bitcnt + 2'd1;
                    end
                end else if (r_idle == TO_LAST) begin
                    w_shift_nxt  = '0;
                    w_bitcnt_nxt = '0;
                    w_idle_nxt   = '0;
                    w_state_nxt  = P_IDLE;
                end else begin
                    w_idle_nxt = r_idle + 16'd1;
                end
            end
            P_HOLD: begin
                if (key_clear || r_hold == HOLD_LAST) begin
                    w_pwd_nxt   = '0;
                    w_hold_nxt  = '0;
                    w_state_nxt = P_IDLE;
                end else begin
                    w_hold_nxt = r_hold + 8'd1;
                end
            end
            default: begin
                w_state_nxt = P_IDLE;
            end
        endcase
    end

    assign sensor_entry  = r_entry;
    assign sensor_exit   = r_exit;
    assign event_dropped = r_dropped;
    assign password      = r_pwd;
    assign pwd_valid     = (r_state == P_HOLD);
    assign key_busy      = (r_state != P_IDLE);

endmodule
